// File: rtl/program_memory_loader.sv
`default_nettype none
// ============================================================================
// Module   : program_memory_loader
// Purpose  : Packs a byte stream little-endian into 32-bit words, writes them
//            into program memory and holds the core in reset until done.
// Revision : 1.0 - initial release
// ============================================================================
module program_memory_loader #(
    parameter int PROGRAM_MEMORY_DEPTH = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic [15:0] word_count_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_data_i,
    output logic        byte_ready_o,
    output logic        Mem_Write_o,
    output logic [31:0] Address_o,
    output logic [31:0] Write_Data_o,
    output logic        cpu_reset_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o
);

    localparam logic [2:0]  C_IDLE    = 3'd0;
    localparam logic [2:0]  C_COLLECT = 3'd1;
    localparam logic [2:0]  C_WRITE   = 3'd2;
    localparam logic [2:0]  C_DONE    = 3'd3;
    localparam logic [2:0]  C_ERROR   = 3'd4;
    localparam logic [15:0] C_DEPTH   = 16'(PROGRAM_MEMORY_DEPTH);

    logic [2:0]  state_q,    state_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [15:0] word_idx_q, word_idx_d;
    logic [15:0] count_q,    count_d;
    logic [23:0] data_q,     data_d;
    logic [31:0] wdata_q,    wdata_d;
    logic [31:0] addr_q,     addr_d;

    logic        w_accept;
    logic [15:0] w_idx_next;

    assign w_accept   = byte_valid_i && (state_q == C_COLLECT);
    assign w_idx_next = word_idx_q + 16'd1;

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        word_idx_d = word_idx_q;
        count_d    = count_q;
        data_d     = data_q;
        wdata_d    = wdata_q;
        addr_d     = addr_q;

        case (state_q)
            C_IDLE, C_DONE, C_ERROR: begin
                if (start_i) begin
                    if (word_count_i == 16'd0) begin
                        state_d = C_DONE;
                    end else if (word_count_i > C_DEPTH) begin
                        state_d = C_ERROR;
                    end else begin
                        count_d    = word_count_i;
                        word_idx_d = 16'd0;
                        byte_cnt_d = 2'd0;
                        state_d    = C_COLLECT;
                    end
                end
            end
            C_COLLECT: begin
                if (w_accept) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    case (byte_cnt_q)
                        2'd0: data_d[7:0]   = byte_data_i;
                        2'd1: data_d[15:8]  = byte_data_i;
                        2'd2: data_d[23:16] = byte_data_i;
                        2'd3: begin
                            // Last byte bypasses the holding register straight into the output word
                            wdata_d = {byte_data_i, data_q};
                            addr_d  = {14'd0, word_idx_q, 2'b00};
                            state_d = C_WRITE;
                        end
                    endcase
                end
            end
            C_WRITE: begin
                word_idx_d = w_idx_next;
                byte_cnt_d = 2'd0;
                state_d    = (w_idx_next == count_q) ? C_DONE : C_COLLECT;
            end
            default: state_d = C_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= C_IDLE;
            byte_cnt_q <= 2'd0;
            word_idx_q <= 16'd0;
            count_q    <= 16'd0;
            data_q     <= 24'd0;
            wdata_q    <= 32'd0;
            addr_q     <= 32'd0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            word_idx_q <= word_idx_d;
            count_q    <= count_d;
            data_q     <= data_d;
            wdata_q    <= wdata_d;
            addr_q     <= addr_d;
        end
    end

    assign byte_ready_o = (state_q == C_COLLECT);
    assign Mem_Write_o  = (state_q == C_WRITE);
    assign busy_o       = (state_q == C_COLLECT) || (state_q == C_WRITE);
    assign cpu_reset_o  = (state_q == C_DONE);
    assign done_o       = (state_q == C_DONE);
    assign error_o      = (state_q == C_ERROR);
    assign Address_o    = addr_q;
    assign Write_Data_o = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_program_memory_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_program_memory_loader
// Purpose  : Randomised self-checking bench for program_memory_loader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_program_memory_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_i;
    logic [15:0] word_count_i;
    logic        byte_valid_i;
    logic [7:0]  byte_data_i;
    logic        byte_ready_o;
    logic        Mem_Write_o;
    logic [31:0] Address_o;
    logic [31:0] Write_Data_o;
    logic        cpu_reset_o;
    logic        busy_o;
    logic        done_o;
    logic        error_o;

    program_memory_loader #(.PROGRAM_MEMORY_DEPTH(64)) dut (
        .clk          (clk),
        .reset        (reset),
        .start_i      (start_i),
        .word_count_i (word_count_i),
        .byte_valid_i (byte_valid_i),
        .byte_data_i  (byte_data_i),
        .byte_ready_o (byte_ready_o),
        .Mem_Write_o  (Mem_Write_o),
        .Address_o    (Address_o),
        .Write_Data_o (Write_Data_o),
        .cpu_reset_o  (cpu_reset_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .error_o      (error_o)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  stim [256];
    logic [31:0] wr_addr [$];
    logic [31:0] wr_data [$];
    int          g_hs, g_first_hs, g_hs4, g_first_wr, g_done_cyc;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, ".byte_ready_o"}, 32'(byte_ready_o), 32'd0);
        check_eq({tag, ".Mem_Write_o"},  32'(Mem_Write_o),  32'd0);
        check_eq({tag, ".Address_o"},    Address_o,         32'd0);
        check_eq({tag, ".Write_Data_o"}, Write_Data_o,      32'd0);
        check_eq({tag, ".cpu_reset_o"},  32'(cpu_reset_o),  32'd0);
        check_eq({tag, ".busy_o"},       32'(busy_o),       32'd0);
        check_eq({tag, ".done_o"},       32'(done_o),       32'd0);
        check_eq({tag, ".error_o"},      32'(error_o),      32'd0);
    endtask

    task automatic randomize_stim();
        for (int i = 0; i < 256; i++) stim[i] = 8'($urandom);
    endtask

    // mode 0: continuous, 1: valid every other cycle, 2: random valid,
    // 3: continuous with a stray start pulse in the middle of the load
    task automatic run_load(input int n, input int mode, input int abort_after);
        int  bidx;
        bit  v;
        bit  finished;
        int  budget;
        wr_addr.delete();
        wr_data.delete();
        bidx = 0; finished = 0; budget = 20 * n + 50;
        g_first_hs = -1; g_hs4 = -1; g_first_wr = -1; g_done_cyc = -1;
        @(negedge clk);
        start_i = 1'b1; word_count_i = 16'(n); byte_valid_i = 1'b0;
        @(negedge clk);
        start_i = 1'b0;
        check_eq("cpu_reset_after_start", 32'(cpu_reset_o), 32'(n == 0));
        check_eq("busy_after_start",      32'(busy_o),      32'(n >= 1 && n <= 64));
        check_eq("error_after_start",     32'(error_o),     32'(n > 64));
        for (int cyc = 0; cyc < budget; cyc++) begin
            if (done_o || error_o) begin
                g_done_cyc = cyc; finished = 1; break;
            end
            if (abort_after > 0 && bidx >= abort_after) begin
                finished = 1; break;
            end
            case (mode)
                1:       v = (cyc % 2 == 0);
                2:       v = 1'($urandom);
                default: v = 1'b1;
            endcase
            start_i      = (mode == 3 && cyc == 2);
            word_count_i = (mode == 3 && cyc == 2) ? 16'd7 : word_count_i;
            byte_valid_i = v;
            byte_data_i  = v ? stim[bidx % 256] : 8'($urandom);
            if (Mem_Write_o) begin
                wr_addr.push_back(Address_o);
                wr_data.push_back(Write_Data_o);
                if (g_first_wr < 0) g_first_wr = cyc;
                check_eq("ready_in_write", 32'(byte_ready_o), 32'd0);
            end
            if (busy_o) check_eq("core_held_while_busy", 32'(cpu_reset_o), 32'd0);
            if (v && byte_ready_o) begin
                if (g_first_hs < 0) g_first_hs = cyc;
                bidx++;
                if (bidx == 4) g_hs4 = cyc;
            end
            @(negedge clk);
        end
        start_i = 1'b0;
        byte_valid_i = 1'b0;
        g_hs = bidx;
        check_eq("load_finished_in_budget", 32'(finished), 32'd1);
    endtask

    task automatic verify_load(input int n);
        check_eq("n_writes",   32'(wr_addr.size()), 32'(n));
        check_eq("handshakes", 32'(g_hs),           32'(4 * n));
        for (int i = 0; i < n && i < wr_addr.size(); i++) begin
            check_eq("wr_addr", wr_addr[i], 32'(i * 4));
            check_eq("wr_data", wr_data[i],
                     {stim[4*i+3], stim[4*i+2], stim[4*i+1], stim[4*i]});
        end
        check_eq("done_o",      32'(done_o),      32'd1);
        check_eq("cpu_reset_o", 32'(cpu_reset_o), 32'd1);
        check_eq("busy_o",      32'(busy_o),      32'd0);
        check_eq("error_o",     32'(error_o),     32'd0);
    endtask

    task automatic verify_timing(input int n);
        check_eq("cycles_to_done",  32'(g_done_cyc - g_first_hs), 32'(5 * n));
        check_eq("first_strobe_lag", 32'(g_first_wr - g_hs4),      32'd1);
    endtask

    initial begin
        reset = 1'b0; start_i = 1'b0; word_count_i = 16'd0;
        byte_valid_i = 1'b0; byte_data_i = 8'd0;
        repeat (3) @(negedge clk);
        check_all_zero("in_reset");
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("idle");

        // Two known instructions
        randomize_stim();
        stim[0] = 8'h13; stim[1] = 8'h05; stim[2] = 8'hA0; stim[3] = 8'h00;
        stim[4] = 8'h93; stim[5] = 8'h00; stim[6] = 8'h10; stim[7] = 8'h00;
        run_load(2, 0, 0);
        verify_load(2);
        verify_timing(2);
        if (wr_data.size() == 2) begin
            check_eq("known_word0", wr_data[0], 32'h00A00513);
            check_eq("known_word1", wr_data[1], 32'h00100093);
        end

        // Stalled source, same word
        run_load(1, 1, 0);
        verify_load(1);
        check_eq("stall_word", Write_Data_o, 32'h00A00513);

        // Length boundaries
        run_load(0, 0, 0);
        check_eq("zero_len_writes", 32'(wr_addr.size()), 32'd0);
        check_eq("zero_len_done",   32'(done_o),         32'd1);
        run_load(65, 0, 0);
        check_eq("over_len_writes", 32'(wr_addr.size()), 32'd0);
        check_eq("over_len_error",  32'(error_o),        32'd1);
        check_eq("over_len_core",   32'(cpu_reset_o),    32'd0);
        check_eq("over_len_done",   32'(done_o),         32'd0);
        randomize_stim();
        run_load(64, 0, 0);
        verify_load(64);
        verify_timing(64);
        check_eq("last_addr", Address_o, 32'h0000_00FC);

        // Random lengths with a random stalling source
        for (int k = 0; k < 4; k++) begin
            int n;
            n = $urandom_range(1, 8);
            randomize_stim();
            run_load(n, 2, 0);
            verify_load(n);
        end

        // Abort after six bytes of a three-word load
        randomize_stim();
        run_load(3, 0, 6);
        #2 reset = 1'b0;
        #1 check_all_zero("async_abort");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("after_abort");
        randomize_stim();
        run_load(1, 0, 0);
        verify_load(1);

        // Reload from DONE with a stray start pulse during COLLECT
        randomize_stim();
        run_load(1, 3, 0);
        verify_load(1);
        verify_timing(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/program_memory_loader.md
Name: program_memory_loader

Overview:
- Writer side of the program-memory interface. The core only reads program memory; this block fills it.
- Accepts a byte stream over a valid/ready handshake and packs it little-endian into 32-bit words.
- Issues one write per word into the program-memory RAM, holding the core in reset until the load completes.
- Sits between the board-level byte source (UART receiver or debug port) and the program memory / core reset.

Parameters:
PROGRAM_MEMORY_DEPTH, 64, number of 32-bit words in program memory; also the maximum legal load length.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start_i  input  1  single-cycle pulse; begins a load of word_count_i words
word_count_i  input  16  number of words to load; sampled on the accepted start_i
byte_valid_i  input  1  byte source has data on byte_data_i
byte_data_i  input  8  stream byte
byte_ready_o  output  1  loader can accept a byte this cycle
Mem_Write_o  output  1  program-memory write strobe, one cycle per word
Address_o  output  32  byte address of the word being written (word-aligned)
Write_Data_o  output  32  assembled instruction word
cpu_reset_o  output  1  active-low reset to the core; 0 holds the core in reset
busy_o  output  1  load in progress
done_o  output  1  last load completed successfully
error_o  output  1  last start rejected (length out of range)

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; byte counter, word index, data register and Address_o cleared. All outputs 0, including cpu_reset_o (core held) and byte_ready_o. Reset mid-load aborts the load immediately; partially written memory is not cleaned up.
- States: IDLE, COLLECT, WRITE, DONE, ERROR.
- IDLE and DONE, start_i=1:
  - word_count_i = 0: go to DONE. No writes; done_o=1.
  - word_count_i > PROGRAM_MEMORY_DEPTH: go to ERROR. No writes; error_o=1.
  - otherwise: latch the count, clear the word index and byte counter, clear done_o/error_o, go to COLLECT.
- ERROR and start_i=1: same evaluation as IDLE.
- COLLECT:
  - byte_ready_o=1, busy_o=1.
  - A byte is accepted only when byte_valid_i and byte_ready_o are both 1.
  - Byte n of a word (n=0..3) goes to bits [8n+7:8n].
  - The 4th accepted byte moves the state to WRITE on the next edge.
  - byte_valid_i low simply stalls; there is no timeout.
- WRITE (exactly one cycle):
  - Mem_Write_o=1, Write_Data_o = assembled word, Address_o = word_index*4.
  - byte_ready_o=0, busy_o=1.
  - Next edge: increment the index. If the incremented index equals the count, go to DONE; else return to COLLECT with the byte counter at 0.
- DONE: cpu_reset_o=1 (core released), done_o=1, busy_o=0, byte_ready_o=0.
- Mem_Write_o is 0 in every state other than WRITE.
- Write_Data_o and Address_o hold their last values outside WRITE.
- cpu_reset_o is 0 in IDLE, COLLECT, WRITE and ERROR; 1 only in DONE.
- start_i is ignored in COLLECT and WRITE.
- A new start from DONE re-asserts the core reset on the next cycle.
- Throughput: 5 cycles per word at a continuous byte rate. The first write strobe comes 1 cycle after the 4th byte handshake.
- Address arithmetic: the index is 16-bit, zero-extended and shifted left by 2; it cannot exceed DEPTH-1.

Test Plan:
- Reset then idle:
  - Check all outputs 0.
  - Pulse start_i with word_count_i=2 and stream bytes 13,05,A0,00 then 93,00,10,00 with byte_valid_i held high.
  - Expect Mem_Write_o pulses: Address_o=0x0 with Write_Data_o=0x00A00513, then Address_o=0x4 with 0x00100093.
  - Then expect done_o=1 and cpu_reset_o=1, with 10 cycles from the first handshake to DONE.
- Stalled source:
  - Toggle byte_valid_i every other cycle during a 1-word load.
  - Expect an identical written word, exactly 4 handshakes and a single Mem_Write_o pulse.
  - Expect byte_ready_o=0 during the WRITE cycle.
- Length boundaries:
  - word_count_i=0 -> DONE next cycle, no writes.
  - word_count_i=65 -> error_o=1, no writes, cpu_reset_o stays 0.
  - word_count_i=64 -> 64 writes; last Address_o=0xFC.
- Abort: drive reset=0 after 6 bytes of a 3-word load. Expect all outputs 0 asynchronously and state IDLE. A following 1-word load starts at Address_o=0x0.
- Reload and ignored start:
  - A start_i pulse during COLLECT has no effect.
  - From DONE, start_i with count 1 -> cpu_reset_o drops the next cycle and the write goes to Address_o=0x0.
  - done_o returns to 1 afterward.
